extended_binary_gcd_inv: RTL and testbench

//  Multi-cycle extended binary GCD engine (HAC Alg. 14.61) with start/done handshake. Operands are

---
 rtl/extended_binary_gcd_inv.sv | 181 ++++++++++++++++++
 tb/tb_extended_binary_gcd_inv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/extended_binary_gcd_inv.sv
// Multi-cycle extended binary GCD engine with start/done handshake.
// Produces gcd(x,y), signed Bezout coefficients (a*x + b*y = gcd) and the
// normalised modular inverse x^-1 mod y when gcd == 1.
module extended_binary_gcd_inv #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic        [WORD_WIDTH-1:0]   x,
  input  logic        [WORD_WIDTH-1:0]   y,
  output logic                           ready,
  output logic                           done,
  output logic                           error,
  output logic        [WORD_WIDTH-1:0]   gcd_result,
  output logic signed [WORD_WIDTH+1:0]   coeff_i,
  output logic signed [WORD_WIDTH+1:0]   coeff_j,
  output logic        [WORD_WIDTH-1:0]   inv_result,
  output logic                           inv_valid
);

  localparam int COEFF_WIDTH = WORD_WIDTH + 2;
  localparam int EXT_WIDTH   = COEFF_WIDTH + 1;
  localparam int K_WIDTH     = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, STRIP, U_EVEN, V_EVEN, SUB, NORM, DONE
  } state_t;

  state_t state, state_next;

  // Working registers: x'/y' after common-factor stripping, u/v reduction
  // pair, coefficient quadruple and the inverse being normalised.
  logic        [WORD_WIDTH-1:0]  xs, ys, u, v;
  logic signed [COEFF_WIDTH-1:0] a, b, c, d, t;
  logic        [K_WIDTH-1:0]     k;

  logic                          accept;
  logic                          operand_zero;
  logic                          gcd_one;
  logic                          t_in_range;
  logic                          norm_exit;
  logic signed [EXT_WIDTH-1:0]   y_add, x_sub;
  logic signed [COEFF_WIDTH-1:0] ys_ext;

  // Halve an even quantity (val + adj); the sum is formed one bit wider
  // so the intermediate cannot overflow before the arithmetic shift.
  function automatic logic signed [COEFF_WIDTH-1:0] halve(
    input logic signed [COEFF_WIDTH-1:0] val,
    input logic signed [EXT_WIDTH-1:0]   adj
  );
    logic signed [EXT_WIDTH-1:0] s;
    s = $signed({val[COEFF_WIDTH-1], val}) + adj;
    return COEFF_WIDTH'(s >>> 1);
  endfunction

  assign accept       = start & ready;
  assign operand_zero = (xs == '0) || (ys == '0);
  assign gcd_one      = (v == WORD_WIDTH'(1)) && (k == '0);
  assign ys_ext       = $signed({2'b00, ys});
  assign t_in_range   = !t[COEFF_WIDTH-1] && (t < ys_ext);
  assign norm_exit    = !gcd_one || t_in_range;
  assign y_add        = $signed({3'b000, ys});
  assign x_sub        = -$signed({3'b000, xs});

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and the ready indication.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE, DONE: begin
        ready = 1'b1;
        if (start) state_next = CHECK;
      end
      CHECK:   state_next = operand_zero ? DONE : STRIP;
      STRIP:   if (xs[0] | ys[0]) state_next = U_EVEN;
      U_EVEN:  if (u[0]) state_next = V_EVEN;
      V_EVEN:  if (v[0]) state_next = SUB;
      SUB:     state_next = (u == v) ? NORM : U_EVEN;
      NORM:    if (norm_exit) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Iterative datapath: operand capture, stripping, halving, subtraction
  // and inverse normalisation, one step per cycle.
  always_ff @(posedge clk) begin
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          xs <= x;
          ys <= y;
        end
      end
      CHECK: k <= '0;
      STRIP: begin
        if (!xs[0] && !ys[0]) begin
          xs <= xs >> 1;
          ys <= ys >> 1;
          k  <= k + 1'b1;
        end else begin
          u <= xs;
          v <= ys;
          a <= COEFF_WIDTH'(1);
          b <= '0;
          c <= '0;
          d <= COEFF_WIDTH'(1);
        end
      end
      U_EVEN: begin
        if (!u[0]) begin
          u <= u >> 1;
          a <= halve(a, (a[0] | b[0]) ? y_add : '0);
          b <= halve(b, (a[0] | b[0]) ? x_sub : '0);
        end
      end
      V_EVEN: begin
        if (!v[0]) begin
          v <= v >> 1;
          c <= halve(c, (c[0] | d[0]) ? y_add : '0);
          d <= halve(d, (c[0] | d[0]) ? x_sub : '0);
        end
      end
      SUB: begin
        if (u >= v) begin
          u <= u - v;
          a <= a - c;
          b <= b - d;
          t <= c;
        end else begin
          v <= v - u;
          c <= c - a;
          d <= d - b;
        end
      end
      NORM: begin
        if (!norm_exit) t <= t[COEFF_WIDTH-1] ? (t + ys_ext) : (t - ys_ext);
      end
      default: ;
    endcase
  end

  // Result registers and done pulse; results hold until the next run finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done       <= 1'b0;
      error      <= 1'b0;
      gcd_result <= '0;
      coeff_i    <= '0;
      coeff_j    <= '0;
      inv_result <= '0;
      inv_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == CHECK && operand_zero) begin
        done       <= 1'b1;
        error      <= 1'b1;
        gcd_result <= '0;
        coeff_i    <= '0;
        coeff_j    <= '0;
        inv_result <= '0;
        inv_valid  <= 1'b0;
      end else if (state == NORM && norm_exit) begin
        done       <= 1'b1;
        error      <= 1'b0;
        gcd_result <= v << k;
        coeff_i    <= c;
        coeff_j    <= d;
        inv_result <= gcd_one ? t[WORD_WIDTH-1:0] : '0;
        inv_valid  <= gcd_one;
      end
    end
  end

endmodule

// File: tb/tb_extended_binary_gcd_inv.sv
// Directed bench for extended_binary_gcd_inv: a 32-bit and an 8-bit instance,
// expected results from a small Euclid model queued at each start.
module tb_extended_binary_gcd_inv;

  localparam int W       = 32;
  localparam int CW      = W + 2;
  localparam int W8      = 8;
  localparam int CW8     = W8 + 2;
  localparam int TIMEOUT = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, start, start8;
  logic        [W-1:0]  x, y;
  logic                 ready, done, error, inv_valid;
  logic        [W-1:0]  gcd_result, inv_result;
  logic signed [CW-1:0] coeff_i, coeff_j;

  logic        [W8-1:0]  x8, y8;
  logic                  ready8, done8, error8, inv_valid8;
  logic        [W8-1:0]  gcd8, inv8;
  logic signed [CW8-1:0] ci8, cj8;

  extended_binary_gcd_inv #(.WORD_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
    .ready(ready), .done(done), .error(error), .gcd_result(gcd_result),
    .coeff_i(coeff_i), .coeff_j(coeff_j), .inv_result(inv_result),
    .inv_valid(inv_valid)
  );

  extended_binary_gcd_inv #(.WORD_WIDTH(W8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .x(x8), .y(y8),
    .ready(ready8), .done(done8), .error(error8), .gcd_result(gcd8),
    .coeff_i(ci8), .coeff_j(cj8), .inv_result(inv8),
    .inv_valid(inv_valid8)
  );

  typedef struct {
    longint x, y, g, inv;
    logic   iv, err;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   fail_cnt  = 0;

  task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(longint a, longint m);
    exp_t   e;
    longint r0, r1, t0, t1, q, tmp;
    e.x = a; e.y = m; e.inv = 0; e.iv = 1'b0; e.err = 1'b0; e.g = 0;
    if (a == 0 || m == 0) begin
      e.err = 1'b1;
      return e;
    end
    r0 = m; r1 = a % m; t0 = 0; t1 = 1;
    while (r1 != 0) begin
      q = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
    end
    e.g = r0;
    if (r0 == 1) begin
      e.iv  = 1'b1;
      e.inv = (m == 1) ? 0 : (((t0 % m) + m) % m);
    end
    return e;
  endfunction

  task automatic compare(string tag, logic signed [63:0] g, logic signed [63:0] inv,
                         logic iv, logic err, logic signed [63:0] ci, logic signed [63:0] cj);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_gcd"}, g, e.g);
    check({tag, "_error"}, err, e.err);
    check({tag, "_inv_valid"}, iv, e.iv);
    if (e.iv) check({tag, "_inv"}, inv, e.inv);
    if (e.err) begin
      check({tag, "_inv_zero"}, inv, 0);
      check({tag, "_ci_zero"}, ci, 0);
    end else begin
      check({tag, "_bezout"}, ci * e.x + cj * e.y, e.g);
    end
  endtask

  task automatic start32(longint a, longint m);
    @(negedge clk);
    check("ready_before_start", ready, 1);
    start = 1'b1; x = W'(a); y = W'(m);
    sb.push_back(model(a, m));
    @(negedge clk);
    start = 1'b0;
    check("ready_after_accept", ready, 0);
  endtask

  task automatic wait32(string tag, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done_seen"}, done, 1);
    if (done === 1'b1) begin
      compare(tag, gcd_result, inv_result, inv_valid, error, coeff_i, coeff_j);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_ready_done"}, ready, 1);
    end
  endtask

  task automatic op32(string tag, longint a, longint m);
    int cyc;
    start32(a, m);
    wait32(tag, cyc);
  endtask

  initial begin
    int cyc;
    reset = 1'b0; start = 1'b0; start8 = 1'b0;
    x = '0; y = '0; x8 = '0; y8 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_gcd", gcd_result, 0);
    check("rst_coeff_i", coeff_i, 0);
    check("rst_coeff_j", coeff_j, 0);
    check("rst_inv", inv_result, 0);
    check("rst_inv_valid", inv_valid, 0);
    check("rst_ready8", ready8, 1);
    reset = 1'b1;

    // Main function
    op32("x3_y7", 3, 7);
    check("x3_y7_inv_const", inv_result, 5);
    op32("x12_y18", 12, 18);
    check("x12_y18_gcd_const", gcd_result, 6);

    op32("rsa", 65537, 3120);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rsa_hold_inv", inv_result, 2753);
      check("rsa_hold_gcd", gcd_result, 1);
      check("rsa_hold_ready", ready, 1);
      check("rsa_hold_done", done, 0);
    end

    // Zero operands
    start32(0, 9);
    wait32("x0_y9", cyc);
    check("x0_y9_latency_ok", cyc <= 3, 1);
    op32("x9_y0", 9, 0);

    // x==y, y==1, x>y
    op32("x5_y5", 5, 5);
    op32("x1_y1", 1, 1);
    op32("x10_y1", 10, 1);
    op32("x100_y7", 100, 7);
    op32("x48_y64", 48, 64);

    // Restart directly from DONE with mixed operands
    for (int i = 0; i < 4; i++) begin
      op32("rand", longint'($urandom_range(1, 32'h3FFF_FFFF)),
                   longint'($urandom_range(1, 32'h3FFF_FFFF)));
    end

    // 8-bit instance; a start while busy must be ignored
    @(negedge clk);
    start8 = 1'b1; x8 = 8'd255; y8 = 8'd254;
    sb.push_back(model(255, 254));
    @(negedge clk);
    start8 = 1'b0;
    check("w8_ready_after_accept", ready8, 0);
    repeat (2) @(negedge clk);
    start8 = 1'b1; x8 = 8'd6; y8 = 8'd9;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check("w8_done_seen", done8, 1);
    if (done8 === 1'b1) compare("w8", gcd8, inv8, inv_valid8, error8, ci8, cj8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("w8_no_second_done", done8, 0);
      check("w8_hold_inv", inv8, 1);
      check("w8_hold_gcd", gcd8, 1);
    end

    // Reset mid-run discards the operation
    start32(65537, 3120);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_gcd", gcd_result, 0);
    check("midrst_inv", inv_result, 0);
    check("midrst_inv_valid", inv_valid, 0);
    check("midrst_coeff_i", coeff_i, 0);
    check("midrst_coeff_j", coeff_j, 0);
    check("midrst_error", error, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    op32("x35_y64", 35, 64);
    check("x35_y64_inv_const", inv_result, 11);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
